board_row_streamer: RTL

//  Downstream consumer of GameOfLife: snapshots the flat game_board once per generation and

---
 rtl/board_row_streamer.sv | 110 +++++++++++
 1 files changed

// File: rtl/board_row_streamer.sv
// rtl/board_row_streamer.sv - snapshots a Game of Life board per generation and streams it row by row
// Per-frame population, extinction and still-life flags are latched at capture.
module board_row_streamer #(
  parameter  int ROW = 6,
  parameter  int COL = 6,
  localparam int RW  = $clog2(ROW),
  localparam int PW  = $clog2(ROW*COL+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ROW*COL-1:0]   game_board,
  input  logic                 gen_tick,
  output logic [COL-1:0]       row_data,
  output logic [RW-1:0]        row_idx,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic                 row_last,
  output logic                 busy,
  output logic [PW-1:0]        frame_pop,
  output logic                 frame_extinct,
  output logic                 frame_stable,
  output logic [15:0]          gen_count,
  output logic [7:0]           drop_count
);

  localparam logic IDLE   = 1'b0;
  localparam logic STREAM = 1'b1;

  localparam logic [RW-1:0] LAST_ROW = RW'(ROW-1);

  logic                 state;
  logic [ROW*COL-1:0]   snap;
  logic [ROW*COL-1:0]   prev;
  logic                 prev_valid;
  logic [PW-1:0]        pop;
  logic                 accept;

  assign row_valid = (state == STREAM);
  assign busy      = row_valid;
  assign row_last  = row_valid && (row_idx == LAST_ROW);
  assign accept    = row_valid && row_ready;

  always_comb begin
    pop = '0;
    for (int i = 0; i < ROW*COL; i++) begin
      pop = pop + PW'(game_board[i]);
    end
  end

  // Row payload comes straight from the snapshot, so it is stable whenever row_idx is.
  always_comb begin
    row_data = '0;
    for (int r = 0; r < ROW; r++) begin
      if (row_idx == RW'(r)) begin
        row_data = snap[r*COL +: COL];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      snap          <= '0;
      prev          <= '0;
      prev_valid    <= 1'b0;
      row_idx       <= '0;
      frame_pop     <= '0;
      frame_extinct <= 1'b0;
      frame_stable  <= 1'b0;
      gen_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gen_tick) begin
            snap          <= game_board;
            frame_pop     <= pop;
            frame_extinct <= (pop == '0);
            frame_stable  <= prev_valid && (game_board == prev);
            gen_count     <= gen_count + 16'd1;
            row_idx       <= '0;
            state         <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            if (row_idx == LAST_ROW) begin
              row_idx    <= '0;
              prev       <= snap;
              prev_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              row_idx <= row_idx + RW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Any generation arriving while a frame is still going out is lost, including on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (state == STREAM && gen_tick && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end

endmodule
